// File: rtl/dice_turn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dice_turn_sequencer
// Description : Turn controller for the dice race game. Waits for a roll
//               request, handshakes with the dice recognition block, animates
//               the current token one square at a time, detects the winner and
//               passes the turn on.
// Revision    : 1.0 - initial release
// ============================================================================
module dice_turn_sequencer #(
   parameter int NUM_PLAYERS  = 2,
   parameter int BOARD_LEN    = 16,
   parameter int STEP_CYCLES  = 4,
   parameter int DICE_TIMEOUT = 100,
   localparam int PW = $clog2(BOARD_LEN),
   localparam int CW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      is_game,
   input  logic                      roll_tick,
   input  logic                      dice_valid,
   input  logic [2:0]                dice_value,
   output logic                      dice_req,
   output logic [CW-1:0]             cur_player,
   output logic [NUM_PLAYERS*PW-1:0] pos_flat,
   output logic                      step_pulse,
   output logic [2:0]                last_roll,
   output logic                      roll_error,
   output logic                      game_over,
   output logic [CW-1:0]             winner
);

   localparam int SCW = $clog2(STEP_CYCLES + 1);
   localparam int TCW = $clog2(DICE_TIMEOUT + 1);

   localparam logic [PW-1:0]  C_GOAL        = PW'(BOARD_LEN - 1);
   localparam logic [SCW-1:0] C_STEP_LAST   = SCW'(STEP_CYCLES - 1);
   localparam logic [TCW-1:0] C_TMO_LAST    = TCW'(DICE_TIMEOUT - 1);
   localparam logic [CW-1:0]  C_LAST_PLAYER = CW'(NUM_PLAYERS - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_ROLL = 3'd1,
      S_CAPTURE   = 3'd2,
      S_MOVE      = 3'd3,
      S_NEXT_TURN = 3'd4,
      S_GAME_OVER = 3'd5
   } state_t;

   state_t         r_state, w_state;
   logic [PW-1:0]  r_pos [NUM_PLAYERS];
   logic [PW-1:0]  w_pos [NUM_PLAYERS];
   logic [CW-1:0]  r_cur, w_cur;
   logic [2:0]     r_last, w_last;
   logic [2:0]     r_steps, w_steps;
   logic [SCW-1:0] r_step_cnt, w_step_cnt;
   logic [TCW-1:0] r_tmo_cnt, w_tmo_cnt;
   logic           r_dice_req;
   logic           r_step_pulse, w_step_pulse;
   logic           r_roll_error, w_roll_error;
   logic           r_game_over;
   logic [CW-1:0]  r_winner, w_winner;
   logic [PW-1:0]  w_adv;

   // Next-state and next-value logic; dropping is_game overrides every state.
   always_comb begin
      w_state      = r_state;
      w_pos        = r_pos;
      w_cur        = r_cur;
      w_last       = r_last;
      w_steps      = r_steps;
      w_step_cnt   = '0;
      w_tmo_cnt    = '0;
      w_step_pulse = 1'b0;
      w_roll_error = 1'b0;
      w_winner     = r_winner;
      w_adv        = r_pos[r_cur] + 1'b1;

      if (!is_game || r_state == S_IDLE) begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            w_pos[i] = '0;
         end
         w_cur    = '0;
         w_last   = '0;
         w_winner = '0;
         w_state  = is_game ? S_WAIT_ROLL : S_IDLE;
      end else begin
         case (r_state)
            S_WAIT_ROLL: begin
               if (roll_tick) begin
                  w_state = S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               w_tmo_cnt = r_tmo_cnt + 1'b1;
               // A result on the timeout cycle still takes precedence.
               if (dice_valid) begin
                  if (dice_value != 3'd0 && dice_value != 3'd7) begin
                     w_last  = dice_value;
                     w_steps = dice_value;
                     w_state = S_MOVE;
                  end else begin
                     w_roll_error = 1'b1;
                     w_state      = S_WAIT_ROLL;
                  end
               end else if (r_tmo_cnt == C_TMO_LAST) begin
                  w_roll_error = 1'b1;
                  w_state      = S_WAIT_ROLL;
               end
            end
            S_MOVE: begin
               if (r_step_cnt == C_STEP_LAST) begin
                  w_pos[r_cur] = w_adv;
                  w_step_pulse = 1'b1;
                  w_steps      = r_steps - 3'd1;
                  // Reaching the goal ends the move even with steps left.
                  if (w_adv == C_GOAL) begin
                     w_winner = r_cur;
                     w_state  = S_GAME_OVER;
                  end else if (r_steps == 3'd1) begin
                     w_state = S_NEXT_TURN;
                  end
               end else begin
                  w_step_cnt = r_step_cnt + 1'b1;
               end
            end
            S_NEXT_TURN: begin
               // A six grants the same player another turn.
               if (r_last != 3'd6) begin
                  w_cur = (r_cur == C_LAST_PLAYER) ? '0 : r_cur + 1'b1;
               end
               w_state = S_WAIT_ROLL;
            end
            S_GAME_OVER: begin
               w_state = S_GAME_OVER;
            end
            default: begin
               w_state = S_IDLE;
            end
         endcase
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            r_pos[i] <= '0;
         end
         r_cur        <= '0;
         r_last       <= '0;
         r_steps      <= '0;
         r_step_cnt   <= '0;
         r_tmo_cnt    <= '0;
         r_dice_req   <= 1'b0;
         r_step_pulse <= 1'b0;
         r_roll_error <= 1'b0;
         r_game_over  <= 1'b0;
         r_winner     <= '0;
      end else begin
         r_state      <= w_state;
         r_pos        <= w_pos;
         r_cur        <= w_cur;
         r_last       <= w_last;
         r_steps      <= w_steps;
         r_step_cnt   <= w_step_cnt;
         r_tmo_cnt    <= w_tmo_cnt;
         r_dice_req   <= (w_state == S_CAPTURE);
         r_step_pulse <= w_step_pulse;
         r_roll_error <= w_roll_error;
         r_game_over  <= (w_state == S_GAME_OVER);
         r_winner     <= w_winner;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_pos_pack
         assign pos_flat[gi*PW +: PW] = r_pos[gi];
      end
   endgenerate

   assign dice_req   = r_dice_req;
   assign cur_player = r_cur;
   assign step_pulse = r_step_pulse;
   assign last_roll  = r_last;
   assign roll_error = r_roll_error;
   assign game_over  = r_game_over;
   assign winner     = r_winner;

endmodule
`default_nettype wire

// File: doc/dice_turn_sequencer.md
Name: dice_turn_sequencer

Overview:
- Turn controller for the dice race game. Active once the game-start controller has put the system in the game state.
- Sequences each player's turn: waits for a roll request, then runs a req/valid handshake with the camera-based dice recognition block. It then animates the current player's token one square at a time, detects the winner and hands the turn to the next player.
- Outputs feed the VGA overlay renderer and the status LEDs.

Parameters:
- NUM_PLAYERS, 2, number of players (2..4).
- BOARD_LEN, 16, number of squares; square BOARD_LEN-1 is the goal.
- STEP_CYCLES, 4, clk cycles per single-square token move.
- DICE_TIMEOUT, 100, max clk cycles in CAPTURE waiting for dice_valid.
- Derived: PW = $clog2(BOARD_LEN), CW = $clog2(NUM_PLAYERS) (minimum 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- is_game  in  1  high while the game state is active; low forces IDLE.
- roll_tick  in  1  one-cycle debounced roll request.
- dice_valid  in  1  recognition result valid, one-cycle pulse.
- dice_value  in  3  recognised pips; only 1..6 are legal.
- dice_req  out  1  capture request to the recognition block.
- cur_player  out  CW  player whose turn it is.
- pos_flat  out  NUM_PLAYERS*PW  packed positions; player i occupies bits [i*PW +: PW].
- step_pulse  out  1  one-cycle pulse per square moved.
- last_roll  out  3  last accepted dice value; 0 means none yet.
- roll_error  out  1  one-cycle pulse on an illegal value or a timeout.
- game_over  out  1  high in GAME_OVER.
- winner  out  CW  winning player; valid while game_over is high.

Behaviour:
- Reset (synchronous, active-high, clock clk) values:
  - state = IDLE.
  - All positions, cur_player, last_roll, winner = 0.
  - dice_req, step_pulse, roll_error, game_over = 0.
- States: IDLE, WAIT_ROLL, CAPTURE, MOVE, NEXT_TURN, GAME_OVER.
- IDLE:
  - Positions, cur_player and last_roll are cleared every cycle.
  - Goes to WAIT_ROLL on the first cycle is_game = 1.
- In any state, is_game = 0 -> IDLE next cycle. This aborts any handshake: dice_req is low the following cycle and positions clear once in IDLE.
- WAIT_ROLL: roll_tick = 1 -> CAPTURE next cycle. dice_valid is ignored here.
- CAPTURE:
  - dice_req = 1 for every cycle in CAPTURE (registered output).
  - A timeout counter starts at 0 on entry and increments each cycle.
  - dice_valid with dice_value in 1..6:
    - latch last_roll and steps_left = dice_value;
    - go to MOVE; dice_req = 0 the next cycle.
  - dice_valid with value 0 or 7: roll_error pulse, go to WAIT_ROLL; positions unchanged.
  - Counter reaches DICE_TIMEOUT-1 with no dice_valid: roll_error pulse, go to WAIT_ROLL.
  - If dice_valid arrives on the timeout cycle, dice_valid wins.
  - roll_tick is ignored.
- MOVE:
  - A cycle counter counts STEP_CYCLES cycles. On terminal count:
    - position of cur_player increments by 1;
    - step_pulse = 1 for that cycle;
    - steps_left decrements.
  - Position reaches BOARD_LEN-1: stop immediately, even if steps remain. winner = cur_player, game_over = 1, go to GAME_OVER. Positions never exceed BOARD_LEN-1.
  - steps_left reaches 0 without reaching the goal -> NEXT_TURN.
  - Total MOVE time for value v (no win) is v*STEP_CYCLES cycles. First step_pulse comes STEP_CYCLES cycles after entering MOVE.
  - roll_tick and dice_valid are ignored.
- NEXT_TURN (one cycle):
  - last_roll = 6: cur_player is unchanged (extra turn).
  - Otherwise cur_player = (cur_player+1) mod NUM_PLAYERS, wrapping NUM_PLAYERS-1 -> 0.
  - Then go to WAIT_ROLL.
- GAME_OVER:
  - Holds positions, winner and game_over.
  - roll_tick and dice_valid are ignored.
  - Leaves only via is_game = 0 -> IDLE; game_over clears on IDLE entry.
- step_pulse and roll_error are never high in the same cycle. Each is a single-cycle pulse.

Test Plan:
- Defaults; reset, then is_game = 1; roll_tick; dice_valid with value 3 two cycles later -> dice_req high for 2 cycles; 3 step_pulses spaced 4 cycles apart; P0 position = 3; last_roll = 3; cur_player = 1.
- P1 rolls 6 -> P1 position = 6 after 24 MOVE cycles; cur_player stays 1. Next roll 2 -> P1 position = 8; cur_player = 0.
- Enter CAPTURE; apply dice_value = 7, then in a later CAPTURE no dice_valid for 100 cycles -> two roll_error pulses; dice_req drops each time; all positions unchanged; state WAIT_ROLL.
- P0 at 13, rolls 5 -> exactly 2 step_pulses; P0 position = 15; game_over = 1; winner = 0. Later roll_tick and dice_valid have no effect.
- Drop is_game mid-MOVE (after 1 step) -> dice_req = 0; next cycle IDLE, positions = 0, cur_player = 0. Re-assert is_game -> fresh game.
- NUM_PLAYERS = 3: rolls 1, 2, 3 -> cur_player sequence 0 -> 1 -> 2 -> 0; positions 1, 2, 3.
